// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the datapath (slave).
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_source;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               illegal, state, cycle_count, instret_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               illegal, state, cycle_count, instret_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V sequencing FSM: fetch/decode/execute/mem/write-back control.
// Define MC_CTRL_PERF_EN to build the cycle and retired-instruction counters.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_I_EXEC    = 4'd9,
        S_ILLEGAL   = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target (old PC + imm) lands in ALUOut for BRANCH to use.
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXECUTE;
                    OP_ITYPE:          state_d = S_I_EXEC;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b10;
                if (bus.opcode == OP_LOAD)       state_d = S_MEM_READ;
                else if (bus.opcode == OP_STORE) state_d = S_MEM_WRITE;
                else                             state_d = S_ILLEGAL;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_op    = 2'b10;
                state_d        = S_ALU_WB;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b10;
                state_d        = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 2'b10;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                state_d            = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset aborts the instruction: no enables leak out during reset.
        if (reset) ctrl = '0;
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.illegal       = ctrl.illegal;
    assign bus.state         = reset ? 4'd0 : state_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_q, cycle_d, instret_q, instret_d;
    logic        retire;

    assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WRITE) && bus.mem_ready);
    assign cycle_d   = cycle_q + 32'd1;
    assign instret_d = instret_q + {31'd0, retire};

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign bus.cycle_count   = reset ? 32'd0 : cycle_q;
    assign bus.instret_count = reset ? 32'd0 : instret_q;
`else
    assign bus.cycle_count   = 32'd0;
    assign bus.instret_count = 32'd0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector table plus randomized instruction stream for multicycle_control.
module tb_multicycle_control;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       mr;
        logic [3:0] st;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_cyc = 0;
    int   exp_ret = 0;
    vec_t tbl[$];
    vec_t q[$];

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Per-state output table; FETCH's ir_write/pc_write follow mem_ready.
    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic mr, input logic rst);
        logic pw = 0, pwc = 0, ps = 0, io = 0, mrd = 0, mw = 0, ir = 0;
        logic rw = 0, m2r = 0, ill = 0;
        logic [1:0] a = 0, b = 0, op = 0;
        if (!rst) begin
            case (st)
                4'd0:  begin mrd = 1; b = 2'b01; ir = mr; pw = mr; end
                4'd1:  begin a = 2'b01; b = 2'b10; end
                4'd2:  begin a = 2'b10; b = 2'b10; end
                4'd3:  begin mrd = 1; io = 1; end
                4'd4:  begin rw = 1; m2r = 1; end
                4'd5:  begin mw = 1; io = 1; end
                4'd6:  begin a = 2'b10; op = 2'b10; end
                4'd7:  rw = 1;
                4'd8:  begin a = 2'b10; op = 2'b01; pwc = 1; ps = 1; end
                4'd9:  begin a = 2'b10; b = 2'b10; end
                4'd15: ill = 1;
                default: ;
            endcase
        end
        return {pw, pwc, ps, io, mrd, mw, ir, a, b, op, rw, m2r, ill};
    endfunction

    function automatic logic [15:0] got_outs();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_write, bus.mem_to_reg, bus.illegal};
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then take the clock edge.
    task automatic step(input logic r, input logic [6:0] op, input logic m,
                        input logic [3:0] est, input logic done);
        logic [15:0] eo;
        logic [31:0] ec, er;
        reset = r; bus.opcode = op; bus.mem_ready = m;
        @(negedge clk);
        check32("state", {28'd0, bus.state}, {28'd0, est});
        eo = exp_outs(est, m, r);
        n_chk++;
        if (got_outs() !== eo) begin
            n_fail++;
            $display("FAIL outputs: state %0d got %b want %b (t=%0t)", est, got_outs(), eo, $time);
        end
`ifdef MC_CTRL_PERF_EN
        ec = r ? 32'd0 : 32'(exp_cyc);
        er = r ? 32'd0 : 32'(exp_ret);
`else
        ec = 32'd0;
        er = 32'd0;
`endif
        check32("cycle_count", bus.cycle_count, ec);
        check32("instret_count", bus.instret_count, er);
        @(posedge clk); #1;
        if (r) begin
            exp_cyc = 0;
            exp_ret = 0;
        end else begin
            exp_cyc++;
            if (done) exp_ret++;
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected state walk built from instruction class and chosen stall counts.
    task automatic build_instr(input int cls, input int fst, input int mst);
        vec_t v;
        logic [6:0] ops[5] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
        v.rst = 0; v.op = ops[cls]; v.done = 0;
        for (int i = 0; i < fst; i++) begin v.st = 0; v.mr = 0; q.push_back(v); end
        v.st = 0; v.mr = 1; q.push_back(v);
        v.st = 1; v.mr = rbit(); q.push_back(v);
        case (cls)
            0, 1: begin
                v.st = (cls == 0) ? 4'd6 : 4'd9; v.mr = rbit(); q.push_back(v);
                v.st = 7; v.mr = rbit(); v.done = 1; q.push_back(v);
            end
            2, 3: begin
                v.st = 2; v.mr = rbit(); q.push_back(v);
                for (int i = 0; i < mst; i++) begin
                    v.st = (cls == 2) ? 4'd3 : 4'd5; v.mr = 0; q.push_back(v);
                end
                v.st = (cls == 2) ? 4'd3 : 4'd5; v.mr = 1; v.done = (cls == 3); q.push_back(v);
                if (cls == 2) begin v.st = 4; v.mr = rbit(); v.done = 1; q.push_back(v); end
            end
            default: begin
                v.st = 8; v.mr = rbit(); v.done = 1; q.push_back(v);
            end
        endcase
    endtask

    task automatic run_q();
        while (q.size() > 0) begin
            vec_t v = q.pop_front();
            step(v.rst, v.op, v.mr, v.st, v.done);
        end
    endtask

    initial begin
        reset = 1; bus.opcode = OP_R; bus.mem_ready = 1;
        // {rst, opcode, mem_ready, expected state, retires on this edge}
        tbl = '{
            '{1, OP_R, 1, 0, 0}, '{1, OP_R, 1, 0, 0},
            '{0, OP_R, 1, 0, 0}, '{0, OP_R, 1, 1, 0}, '{0, OP_R, 1, 6, 0}, '{0, OP_R, 1, 7, 1},
            '{0, OP_LD, 1, 0, 0}, '{0, OP_LD, 1, 1, 0}, '{0, OP_LD, 1, 2, 0},
            '{0, OP_LD, 0, 3, 0}, '{0, OP_LD, 0, 3, 0}, '{0, OP_LD, 0, 3, 0},
            '{0, OP_LD, 1, 3, 0}, '{0, OP_LD, 1, 4, 1},
            '{0, OP_BR, 1, 0, 0}, '{0, OP_BR, 1, 1, 0}, '{0, OP_BR, 1, 8, 1},
            '{0, OP_ST, 0, 0, 0}, '{0, OP_ST, 0, 0, 0}, '{0, OP_ST, 1, 0, 0},
            '{0, OP_ST, 1, 1, 0}, '{0, OP_ST, 1, 2, 0}, '{0, OP_ST, 1, 5, 1},
            '{0, OP_I, 1, 0, 0}, '{0, OP_I, 0, 1, 0}, '{0, OP_I, 0, 9, 0}, '{0, OP_I, 0, 7, 1},
            '{0, OP_LD, 1, 0, 0}, '{0, OP_LD, 1, 1, 0}, '{0, OP_LD, 1, 2, 0},
            '{0, OP_LD, 0, 3, 0}, '{1, OP_LD, 0, 0, 0},
            '{0, OP_XX, 1, 0, 0}, '{0, OP_XX, 1, 1, 0}
        };
        foreach (tbl[i]) step(tbl[i].rst, tbl[i].op, tbl[i].mr, tbl[i].st, tbl[i].done);

        // Absorbing ILLEGAL for 10 cycles regardless of mem_ready, then reset out.
        for (int i = 0; i < 10; i++) step(0, OP_XX, rbit(), 4'd15, 0);
        step(1, OP_XX, 1, 4'd0, 0);
        step(0, OP_R, 1, 4'd0, 0);
        step(0, OP_R, 1, 4'd1, 0);

        // Three stall-free stores from a fresh reset.
        step(1, OP_ST, 1, 4'd0, 0);
        for (int i = 0; i < 3; i++) build_instr(3, 0, 0);
        run_q();
`ifdef MC_CTRL_PERF_EN
        check32("store3 instret", bus.instret_count, 32'd3);
        check32("store3 cycles", bus.cycle_count, 32'd12);
`else
        check32("store3 instret off", bus.instret_count, 32'd0);
        check32("store3 cycles off", bus.cycle_count, 32'd0);
`endif
        step(0, OP_ST, 1, 4'd0, 0);

        // Random instruction stream with random memory stalls.
        step(1, OP_R, 1, 4'd0, 0);
        for (int n = 0; n < 300; n++) begin
            build_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 3)));
            run_q();
        end
        step(0, OP_R, 0, 4'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multi-cycle RISC-V core. It walks each instruction through fetch, decode, execute, memory and write-back steps, and drives the datapath mux selects and register enables. It supplies the 2-bit ALU operation class consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = decode from funct. It stalls on a single ready handshake from the shared instruction/data memory.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0] from the instruction register; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero flag set
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = immediate
- alu_op  out  2  ALU operation class to ALU control
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = memory data register
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state encoding (debug)
- cycle_count  out  32  performance counter, see Configuration
- instret_count  out  32  performance counter, see Configuration

## Operation
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, I_EXEC=9, ILLEGAL=15. All other encodings go to FETCH.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00; this precomputes the branch target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADDR
  - 0110011 → EXECUTE
  - 0010011 → I_EXEC
  - 1100011 → BRANCH
  - any other opcode → ILLEGAL
- MEM_ADDR: alu_src_a=10, alu_src_b=10, alu_op=00. Next state is MEM_READ for load, MEM_WRITE for store; opcode is re-examined here.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, then go to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready, then go to FETCH.
- EXECUTE: alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALU_WB.
- I_EXEC: alu_src_a=10, alu_src_b=10, alu_op=00 (addi only), then go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, then go to FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1, then go to FETCH.
- ILLEGAL: illegal=1. The state is absorbing; only reset leaves it.
- Memory requests (mem_read, mem_write) stay asserted and constant for every cycle spent waiting on mem_ready.

## Timing
- State is registered. Outputs are decoded combinationally from state; ir_write and pc_write are additionally gated by mem_ready.
- Reset:
  - While reset=1, every output is forced to 0, including state and both counters.
  - On the first edge with reset=1, state becomes FETCH and the counters clear.
  - Reset asserted in any state, including ILLEGAL or mid-wait, aborts the instruction with no further write enables.
- Instruction latency in cycles with mem_ready held at 1:
  - R-type 4, I-type 4, load 5, store 4, branch 3, ILLEGAL never completes.
  - Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored in every state that has no memory request.

## Configuration
- Macro MC_CTRL_PERF_EN.
- Defined: cycle_count increments on every clock edge where reset=0. instret_count increments on each edge that leaves MEM_WB, ALU_WB or BRANCH, or leaves MEM_WRITE with mem_ready=1. Both counters are 32-bit and wrap from FFFFFFFF to 0. Neither counter increments in ILLEGAL except cycle_count.
- Undefined: both counters are tied to constant 0 and no counter flops are built; all other behaviour is identical.

## Test plan
- Reset held 2 cycles, then released with mem_ready=1 and an R-type opcode → state goes 0,1,6,7,0. reg_write=1 only in state 7. alu_op=10 only in state 6.
- Load (0000011) with mem_ready low for 3 cycles in MEM_READ → state sequence 0,1,2,3,3,3,3,4,0. mem_read=1 and iord=1 throughout the wait. Total 8 cycles.
- Branch (1100011) → state sequence 0,1,8,0. In state 8: pc_write_cond=1, pc_source=1, alu_op=01, alu_src_a=10, alu_src_b=00.
- Opcode 1111111 in DECODE → state 15 and illegal=1 held for 10 cycles. Asserting reset mid-hold gives illegal=0 and state=0 on the next edge.
- FETCH with mem_ready=0 for 2 cycles → ir_write=0 and pc_write=0 while stalled, both 1 exactly in the completing cycle.
- With MC_CTRL_PERF_EN: 3 back-to-back stores with no stalls → instret_count=3 and cycle_count=12 at the fourth FETCH entry. Without the macro both counters read 0.
